// File: rtl/puvvada_says_btn_input.sv
// puvvada_says_btn_input: synchronizes and debounces the four colour buttons,
// arbitrates them into one accepted press and hands that press to the state
// machine over a valid/ack handshake. Chords and bounces never produce a press.
module puvvada_says_btn_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Btn_U,
  input  logic       Btn_R,
  input  logic       Btn_D,
  input  logic       Btn_L,
  input  logic       En,
  input  logic       btn_ack,
  output logic       btn_valid,
  output logic [1:0] btn_code,
  output logic       overrun,
  output logic       busy,
  output logic [7:0] press_count
);

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned CODE_W  = 2;
  localparam int unsigned COUNT_W = 8;

  // Terminal count of a debounce window (press or release).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
  localparam logic [1:0] ST_HOLD        = 2'd2;
  localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

  // Button vectors are ordered {U, R, D, L}; code c lives at bit (3 - c).
  logic [NUM_BTN-1:0] raw_vec;
  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] vec;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [CODE_W-1:0]  cur;
  logic [CODE_W-1:0]  cur_next;

  logic [CODE_W-1:0]  arm_code_c;
  logic [NUM_BTN-1:0] cur_onehot_c;
  logic               accept_c;
  logic               ack_take_c;

  assign raw_vec = {Btn_U, Btn_R, Btn_D, Btn_L};

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_meta <= '0;
      vec       <= '0;
    end else begin
      sync_meta <= raw_vec;
      vec       <= sync_meta;
    end
  end

  // Fixed-priority pick of the button to arm on: U, then R, then D, then L.
  always_comb begin
    arm_code_c = CODE_W'(3);
    if (vec[3]) begin
      arm_code_c = CODE_W'(0);
    end else if (vec[2]) begin
      arm_code_c = CODE_W'(1);
    end else if (vec[1]) begin
      arm_code_c = CODE_W'(2);
    end
  end

  // Only the armed button, alone, keeps a press debounce alive.
  assign cur_onehot_c = NUM_BTN'(4'b1000 >> cur);

  // State register plus debounce counter and armed-button latch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cur   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cur   <= cur_next;
      busy  <= (state_next != ST_IDLE);
    end
  end

  // Next-state logic: arm, debounce press, wait for release, debounce release.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cur_next   = cur;
    accept_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (En && (vec != '0)) begin
          state_next = ST_DEB_PRESS;
          cur_next   = arm_code_c;
        end
      end
      ST_DEB_PRESS: begin
        if (!En || (vec != cur_onehot_c)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
          accept_c   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (vec == '0) begin
          state_next = ST_DEB_RELEASE;
          cnt_next   = '0;
        end
      end
      ST_DEB_RELEASE: begin
        if (vec != '0) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // An ack retires the pending press before a same-edge accept is considered.
  assign ack_take_c = btn_ack & btn_valid;

  // Handshake register: load a new press, retire on ack, flag dropped presses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      btn_valid   <= 1'b0;
      btn_code    <= '0;
      overrun     <= 1'b0;
      press_count <= '0;
    end else begin
      if (ack_take_c) begin
        btn_valid <= 1'b0;
      end
      if (accept_c) begin
        if (btn_valid && !ack_take_c) begin
          overrun <= 1'b1;
        end else begin
          btn_valid   <= 1'b1;
          btn_code    <= cur;
          press_count <= press_count + COUNT_W'(1);
        end
      end
    end
  end

endmodule
